muldiv_seq: RTL and testbench

//   Iterative multiply/divide unit, parametrised successor to the single-cycle ALU. Executes unsigned
//   MUL, MULHU, DIVU and REMU over XLEN-bit operands, retiring one bit per clock.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 139 +++++++++++++
 tb/tb_muldiv_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM state codes and a small operation-class helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic is_div(input op_t op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the control unit (master) and muldiv_seq (slave).
interface muldiv_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  // Handshake: the master raises start with op/srcA/srcB; the request is taken on a
  // rising edge while busy==0 or done==1, otherwise it is ignored. done pulses for one
  // cycle with result/div_by_zero valid; those stay stable until the next completion.
  logic            start;
  op_t             op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            div_by_zero;

  modport master (
    output start, op, srcA, srcB,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, srcA, srcB,
    output busy, done, result, div_by_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// trial-subtract divide step, purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          ge;

  always_comb begin
    // Multiply: {acc,lo} is the 2*XLEN product register, multiplier consumed from lo[0].
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    // Divide: acc is the remainder, lo shifts dividend bits out and quotient bits in.
    shifted = {acc, lo[XLEN-1]};
    trial   = shifted - {1'b0, opnd};
    ge      = ~trial[XLEN];
    if (is_div) begin
      acc_nxt = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ge};
    end else begin
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one bit per clock.
// Optional MULDIV_EARLY_OUT_EN: trivial operands finish directly after the accepting edge.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus,
  output state_t  dbg_state
);

  localparam int              CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t          state, state_nxt;
  logic            accept, busy, done, finish;
  logic [CNT_W-1:0] cnt;
  op_t             op_q;
  logic            op_div;
  logic [XLEN-1:0] acc_q, lo_q, opnd_q;
  logic [XLEN-1:0] acc_step, lo_step;
  logic [XLEN-1:0] res_q, fin_res;
  logic            dbz_q, fin_dbz;

`ifdef MULDIV_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early     = is_div(bus.op) ? (bus.srcB == '0) : ((bus.srcA == '0) || (bus.srcB == '0));
    early_res = '0;
    case (bus.op)
      OP_DIVU: early_res = '1;
      OP_REMU: early_res = bus.srcA;
      default: early_res = '0;
    endcase
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (accept && early) state_nxt = S_DONE;
`endif
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign op_div = is_div(op_q);
  assign finish = (state == S_RUN) && (cnt == LAST);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_div),
    .acc     (acc_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_step),
    .lo_nxt  (lo_step)
  );

  // The last iteration's outputs are captured directly into the result register.
  always_comb begin
    fin_res = lo_step;
    case (op_q)
      OP_MULHU, OP_REMU: fin_res = acc_step;
      default:           fin_res = lo_step;
    endcase
    fin_dbz = op_div && (opnd_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_MUL;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      res_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.op;
        cnt    <= '0;
        acc_q  <= '0;
        opnd_q <= is_div(bus.op) ? bus.srcB : bus.srcA;
        lo_q   <= is_div(bus.op) ? bus.srcA : bus.srcB;
      end else if (state == S_RUN) begin
        acc_q <= acc_step;
        lo_q  <= lo_step;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        res_q <= fin_res;
        dbz_q <= fin_dbz;
      end
`ifdef MULDIV_EARLY_OUT_EN
      // A trivial divide can only be a zero divisor, so the flag follows the op class.
      if (accept && early) begin
        res_q <= early_res;
        dbz_q <= is_div(bus.op);
      end
`endif
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random bench for muldiv_seq at XLEN=32 and XLEN=8, scoreboard-checked.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg32, dbg8;

  logic [32:0] exp_q[$];
  logic [8:0]  exp8_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  muldiv_if #(.XLEN(32)) b32 ();
  muldiv_if #(.XLEN(8))  b8 ();

  muldiv_seq #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(b32), .dbg_state(dbg32));
  muldiv_seq #(.XLEN(8))  u8  (.clk(clk), .rst(rst), .bus(b8),  .dbg_state(dbg8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic trivial(input op_t op, input logic [63:0] a, input logic [63:0] b);
    return (op == OP_DIVU || op == OP_REMU) ? (b == 0) : (a == 0 || b == 0);
  endfunction

  // Reference model: {div_by_zero, result} for an xl-bit unit, from plain arithmetic.
  function automatic logic [64:0] model(input op_t op, input logic [63:0] a,
                                        input logic [63:0] b, input int xl);
    logic [63:0]  mask;
    logic [127:0] p, ph;
    mask = (64'd1 << xl) - 64'd1;
    p    = {64'd0, a} * {64'd0, b};
    ph   = p >> xl;
    case (op)
      OP_MUL:   return {1'b0, p[63:0] & mask};
      OP_MULHU: return {1'b0, ph[63:0] & mask};
      OP_DIVU:  return (b == 0) ? {1'b1, mask} : {1'b0, a / b};
      default:  return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // Scoreboards: every done pulse pops and compares one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && b32.done === 1'b1) begin
      logic [32:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
      check("sb32", 64'({b32.div_by_zero, b32.result}), 64'(e));
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && b8.done === 1'b1) begin
      logic [8:0] e;
      e = (exp8_q.size() != 0) ? exp8_q.pop_front() : 9'bx;
      check("sb8", 64'({b8.div_by_zero, b8.result}), 64'(e));
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run32(input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp, input string tag);
    int e, lat;
    bit busy_ok;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (trivial(op, 64'(a), 64'(b))) lat = 1;
`endif
    b32.start = 1'b1; b32.op = op; b32.srcA = a; b32.srcB = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 b32.start = 1'b0;
    e = 1;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      if (b32.done === 1'b1 || e > 100) break;
      if (b32.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      e++;
    end
    check({tag, "_lat"}, 64'(e), 64'(lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run8(input op_t op, input logic [7:0] a, input logic [7:0] b);
    logic [64:0] m;
    int e, lat;
    m = model(op, 64'(a), 64'(b), 8);
    lat = 9;
`ifdef MULDIV_EARLY_OUT_EN
    if (trivial(op, 64'(a), 64'(b))) lat = 1;
`endif
    b8.start = 1'b1; b8.op = op; b8.srcA = a; b8.srcB = b;
    exp8_q.push_back({m[64], m[7:0]});
    @(posedge clk);
    #1 b8.start = 1'b0;
    e = 1;
    while (1) begin
      @(negedge clk);
      if (b8.done === 1'b1 || e > 50) break;
      @(posedge clk);
      e++;
    end
    check("x8_lat", 64'(e), 64'(lat));
  endtask

  initial begin
    int e, n, last;
    op_t r_op;
    logic [7:0] r_a, r_b;

    // Clock/reset
    rst = 1'b1;
    b32.start = 1'b0; b32.op = OP_MUL; b32.srcA = '0; b32.srcB = '0;
    b8.start  = 1'b0; b8.op  = OP_MUL; b8.srcA  = '0; b8.srcB  = '0;
    @(negedge clk);
    check("rst_busy",   64'(b32.busy), 64'd0);
    check("rst_done",   64'(b32.done), 64'd0);
    check("rst_result", 64'(b32.result), 64'd0);
    check("rst_dbz",    64'(b32.div_by_zero), 64'd0);
    check("rst_state",  64'(dbg32), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Directed operations
    run32(OP_MUL,   32'd7,         32'd6,         33'd42,               "mul7x6");
    run32(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE}, "mulhu_max");
    run32(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'd1,                "mul_max");
    run32(OP_DIVU,  32'd100,       32'd7,         33'd14,               "divu100_7");
    run32(OP_REMU,  32'd100,       32'd7,         33'd2,                "remu100_7");
    run32(OP_DIVU,  32'd5,         32'd9,         33'd0,                "divu5_9");
    run32(OP_REMU,  32'd5,         32'd9,         33'd5,                "remu5_9");
    run32(OP_DIVU,  32'd1234,      32'd0,         {1'b1, 32'hFFFF_FFFF}, "divu_dz");
    run32(OP_REMU,  32'd1234,      32'd0,         {1'b1, 32'd1234},     "remu_dz");
    run32(OP_MUL,   32'd0,         32'd5,         33'd0,                "mul_zero");

    // start held high: ignored in RUN, accepted in DONE; operands changed after E0
    b32.start = 1'b1; b32.op = OP_MUL; b32.srcA = 32'd3; b32.srcB = 32'd5;
    exp_q.push_back(33'd15);
    exp_q.push_back(33'd81);
    exp_q.push_back(33'd81);
    @(posedge clk);
    #1 b32.srcA = 32'd9; b32.srcB = 32'd9;
    e = 1; n = 0; last = 0;
    while (n < 3 && e < 200) begin
      @(negedge clk);
      if (b32.done === 1'b1) begin
        if (n > 0) check($sformatf("b2b_gap%0d", n), 64'(e - last), 64'd33);
        last = e;
        n++;
      end
      if (n < 3) begin
        @(posedge clk);
        e++;
      end
    end
    b32.start = 1'b0;
    check("b2b_pulses", 64'(n), 64'd3);

    // Reset during iteration 10 aborts the operation
    b32.start = 1'b1; b32.op = OP_MUL; b32.srcA = 32'h0001_2345; b32.srcB = 32'h0000_0FFF;
    @(posedge clk);
    #1 b32.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_state", 64'(dbg32), 64'(S_RUN));
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   64'(b32.busy), 64'd0);
    check("mid_rst_done",   64'(b32.done), 64'd0);
    check("mid_rst_result", 64'(b32.result), 64'd0);
    check("mid_rst_state",  64'(dbg32), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    run32(OP_DIVU, 32'd100, 32'd7, 33'd14, "post_rst");

    // XLEN=8 random sweep against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      r_op = op_t'(2'($urandom_range(0, 3)));
      r_a  = 8'($urandom_range(0, 255));
      r_b  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r_b = 8'd0;
      if ($urandom_range(0, 9) == 0) r_a = 8'd0;
      run8(r_op, r_a, r_b);
    end
    run8(OP_MULHU, 8'hFF, 8'hFF);

    repeat (3) @(negedge clk);
    check("sb32_drain", 64'(exp_q.size()), 64'd0);
    check("sb8_drain",  64'(exp8_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
